audio_adc_rx: RTL and testbench
===============================

# audio_adc_rx

Serial-to-parallel receiver for the dual-line microphone/ADC link used by the ANC datapath. A frame starts on each falling edge of `aud_lrc`. Each frame then carries one WL-bit two's-complement word, MSB first, on each of two serial lines: `mic_l` for the reference mic and `mic_r` for the error mic. The transmitter drives bits on the falling edge of `aud_bclk`, and this block samples them on the rising edge. The block captures both words, presents them as a parallel pair with a valid/ready handshake, and flags overflow and truncated frames for the adaptive filter front end.

## Interface

Parameters:
- `WL`, default 24: bits per channel word; legal range 2..32.
- `CNT_W`, default 16: width of the frame counter.

Ports:
- `aud_bclk`, in, 1: bit clock; the only clock, rising edge active.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `en`, in, 1: receive enable; when low the FSM is forced to IDLE.
- `aud_lrc`, in, 1: frame alignment; a frame starts on its falling edge.
- `mic_l`, in, 1: serial data line for the left channel (reference mic).
- `mic_r`, in, 1: serial data line for the right channel (error mic).
- `rx_data_l`, out, WL: last complete left word.
- `rx_data_r`, out, WL: last complete right word.
- `rx_valid`, out, 1: the output pair is unconsumed.
- `rx_ready`, in, 1: downstream accepts the pair; a transfer occurs when `rx_valid` and `rx_ready` are both high.
- `rx_overflow`, out, 1: one-cycle pulse when an unconsumed pair is overwritten.
- `frame_err`, out, 1: one-cycle pulse when a frame is truncated by an early frame start.
- `frame_cnt`, out, CNT_W: count of completed frames; wraps.

## Operation

- `lrc_d0` is `aud_lrc` registered on each rising edge of `aud_bclk`.
- `fs_edge = lrc_d0 & ~aud_lrc` marks a frame start.
- FSM states:
  - IDLE: the state after reset and whenever `en` is low. Serial data is ignored. `fs_edge` with `en` high → SHIFT, with `bit_cnt` set to 0.
  - SHIFT: on each rising edge, shift `mic_l` into `sh_l` and `mic_r` into `sh_r` (MSB first), then increment `bit_cnt`. On the edge where `bit_cnt` equals WL-1, the frame completes and the state goes to WAIT.
  - WAIT: serial data is ignored until the next `fs_edge`, which goes to SHIFT with `bit_cnt` set to 0.
- On frame completion:
  - `rx_data_l` ← {`sh_l[WL-2:0]`, `mic_l`}, and `rx_data_r` is loaded the same way from `sh_r` and `mic_r`.
  - `rx_valid` ← 1 and `frame_cnt` ← `frame_cnt` + 1, wrapping at the top of its range.
- Boundary conditions:
  - `fs_edge` while in SHIFT: `frame_err` pulses in the next cycle, the partial word is discarded, and the block restarts SHIFT with `bit_cnt` = 0. Output registers and `frame_cnt` are unchanged.
  - Frame completes while `rx_valid` is high and `rx_ready` is low: the new pair overwrites the old one, `rx_overflow` pulses, and `rx_valid` stays high.
  - Frame completes in the same cycle as a transfer: the new pair is loaded, `rx_valid` stays high, and there is no overflow.
  - Transfer with no completion: `rx_valid` ← 0.
  - `en` falling while in SHIFT: return to IDLE silently with no `frame_err`. The output pair and `rx_valid` are kept.
  - `rst_n` asserted mid-frame: every register clears immediately, and the partial frame is lost.
- No sign extension or rescaling is applied; consumers do their own format alignment.

## Timing

- Reset values:
  - `rx_data_l`, `rx_data_r`: 0.
  - `rx_valid`, `rx_overflow`, `frame_err`: 0.
  - `frame_cnt`: 0.
  - FSM: IDLE, with `lrc_d0` = 0.
- Let rising edge k be the edge where `fs_edge` is seen.
  - The MSB is sampled at edge k+1.
  - The LSB is sampled at edge k+WL.
  - Outputs and `rx_valid` are updated by edge k+WL and are visible in the cycle after it.
- Latency from the LSB on the line to `rx_valid` is one rising edge.
- `frame_err` and `rx_overflow` are registered: high for exactly one cycle, in the cycle after the triggering edge.
- `rx_ready` is sampled on the rising edge. There is no combinational path from `rx_ready` to any output.

## Structure

- Shared package `audio_pkg` holds:
  - the FSM state enum (IDLE, SHIFT, WAIT);
  - the constant `AUD_WL_DEFAULT` = 24.
- Natural sub-module: `audio_shift_in`. It is a WL-bit MSB-first shift register with a load-complete strobe, instantiated once per channel.
- FSM, handshake and counters stay in the top module.

## Test plan

- Basic frame: after a `fs_edge`, send L = 0x123456 and R = 0xFEDCBA.
  - Required: `rx_data_l` = 0x123456 and `rx_data_r` = 0xFEDCBA after edge k+24.
  - `rx_valid` = 1 and `frame_cnt` = 1.
- Backpressure: hold `rx_ready` = 0 across two frames, L = 0x000001 then 0x7FFFFF.
  - Required: exactly one `rx_overflow` pulse, `rx_data_l` = 0x7FFFFF, `rx_valid` still 1.
- Simultaneous events: assert `rx_ready` on the completion edge of the second frame.
  - Required: no overflow, the new pair is presented, `rx_valid` = 1.
- Truncated frame: start a new `fs_edge` after 10 bits.
  - Required: one `frame_err` pulse, outputs unchanged, and the following full frame of 0x800000 is captured correctly.
- Reset and enable: assert `rst_n` = 0 at bit 12; separately, hold `en` = 0 for two frames.
  - Required: all outputs read 0 after reset; with `en` low, `frame_cnt` does not advance; the first frame after `en` rises is captured.
- Randomized loopback: 1000 frames of random words, random `rx_ready`, scoreboard compare.
  - Required: no mismatch, and `frame_cnt` wraps correctly with `CNT_W` = 4.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types and constants for the audio serial receive path.
package audio_pkg;

   localparam int unsigned AUD_WL_DEFAULT = 24;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      WAIT  = 2'd2
   } aud_state_e;

endpackage

// File: rtl/audio_adc_rx_if.sv
// Parallel output side of audio_adc_rx: word pair, valid/ready handshake and status strobes.
interface audio_adc_rx_if
   import audio_pkg::*;
#(
   parameter int unsigned WL    = AUD_WL_DEFAULT,
   parameter int unsigned CNT_W = 16
) ();

   logic [WL-1:0]    rx_data_l;
   logic [WL-1:0]    rx_data_r;
   logic             rx_valid;
   logic             rx_ready;
   logic             rx_overflow;
   logic             frame_err;
   logic [CNT_W-1:0] frame_cnt;

   modport master (
      output rx_data_l, rx_data_r, rx_valid, rx_overflow, frame_err, frame_cnt,
      input  rx_ready
   );

   modport slave (
      input  rx_data_l, rx_data_r, rx_valid, rx_overflow, frame_err, frame_cnt,
      output rx_ready
   );

endinterface

// File: rtl/audio_shift_in.sv
// WL-bit MSB-first serial shifter; load captures the completed word including the bit on sdi.
module audio_shift_in #(
   parameter int unsigned WL = 24
) (
   input  logic          aud_bclk,
   input  logic          rst_n,
   input  logic          shift_en,
   input  logic          load,
   input  logic          sdi,
   output logic [WL-1:0] word
);

   // Only WL-1 history bits are needed: the LSB arrives on sdi during the load edge.
   logic [WL-2:0] sh;
   logic [WL-1:0] sh_nxt;

   assign sh_nxt = {sh, sdi};

   always_ff @(posedge aud_bclk or negedge rst_n) begin
      if (!rst_n) begin
         sh   <= '0;
         word <= '0;
      end else begin
         if (shift_en) sh <= sh_nxt[WL-2:0];
         if (load)     word <= sh_nxt;
      end
   end

endmodule

// File: rtl/audio_adc_rx.sv
// Dual-line serial mic/ADC receiver: frame on aud_lrc falling edge, WL bits per line, valid/ready output.
module audio_adc_rx
   import audio_pkg::*;
#(
   parameter int unsigned WL    = AUD_WL_DEFAULT,
   parameter int unsigned CNT_W = 16
) (
   input  logic           aud_bclk,
   input  logic           rst_n,
   input  logic           en,
   input  logic           aud_lrc,
   input  logic           mic_l,
   input  logic           mic_r,
   audio_adc_rx_if.master rx
);

   localparam int unsigned      BC_W    = $clog2(WL);
   localparam logic [BC_W-1:0]  BC_LAST = BC_W'(WL - 1);

   aud_state_e       state_q, state_d;
   logic [BC_W-1:0]  bit_cnt_q;
   logic             lrc_d0;
   logic             fs_edge;
   logic             shift_en, cnt_clr, complete, err_set;
   logic             rx_valid_q, rx_overflow_q, frame_err_q;
   logic [CNT_W-1:0] frame_cnt_q;
   logic [WL-1:0]    data_l, data_r;

   assign fs_edge = lrc_d0 & ~aud_lrc;

   always_ff @(posedge aud_bclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         lrc_d0    <= 1'b0;
         bit_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         lrc_d0  <= aud_lrc;
         if (cnt_clr)       bit_cnt_q <= '0;
         else if (shift_en) bit_cnt_q <= bit_cnt_q + 1'b1;
      end
   end

   // A frame start inside SHIFT restarts the word and flags the truncation.
   always_comb begin
      state_d  = state_q;
      shift_en = 1'b0;
      cnt_clr  = 1'b0;
      complete = 1'b0;
      err_set  = 1'b0;
      if (!en) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE, WAIT: begin
               if (fs_edge) begin
                  state_d = SHIFT;
                  cnt_clr = 1'b1;
               end
            end
            SHIFT: begin
               if (fs_edge) begin
                  cnt_clr = 1'b1;
                  err_set = 1'b1;
               end else begin
                  shift_en = 1'b1;
                  if (bit_cnt_q == BC_LAST) begin
                     complete = 1'b1;
                     state_d  = WAIT;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge aud_bclk or negedge rst_n) begin
      if (!rst_n) begin
         rx_valid_q    <= 1'b0;
         rx_overflow_q <= 1'b0;
         frame_err_q   <= 1'b0;
         frame_cnt_q   <= '0;
      end else begin
         rx_overflow_q <= complete & rx_valid_q & ~rx.rx_ready;
         frame_err_q   <= err_set;
         if (complete) begin
            rx_valid_q  <= 1'b1;
            frame_cnt_q <= frame_cnt_q + 1'b1;
         end else if (rx_valid_q && rx.rx_ready) begin
            rx_valid_q <= 1'b0;
         end
      end
   end

   audio_shift_in #(.WL(WL)) u_shift_l (
      .aud_bclk (aud_bclk),
      .rst_n    (rst_n),
      .shift_en (shift_en),
      .load     (complete),
      .sdi      (mic_l),
      .word     (data_l)
   );

   audio_shift_in #(.WL(WL)) u_shift_r (
      .aud_bclk (aud_bclk),
      .rst_n    (rst_n),
      .shift_en (shift_en),
      .load     (complete),
      .sdi      (mic_r),
      .word     (data_r)
   );

   assign rx.rx_data_l   = data_l;
   assign rx.rx_data_r   = data_r;
   assign rx.rx_valid    = rx_valid_q;
   assign rx.rx_overflow = rx_overflow_q;
   assign rx.frame_err   = frame_err_q;
   assign rx.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_audio_adc_rx.sv
// Directed + randomized bench for audio_adc_rx with a frame-level scoreboard.
module tb_audio_adc_rx;
   import audio_pkg::*;

   localparam int unsigned WL    = 24;
   localparam int unsigned CNT_W = 4;

   logic aud_bclk = 1'b0;
   logic rst_n    = 1'b0;
   logic en       = 1'b0;
   logic aud_lrc  = 1'b0;
   logic mic_l    = 1'b0;
   logic mic_r    = 1'b0;

   audio_adc_rx_if #(.WL(WL), .CNT_W(CNT_W)) rx_if ();

   audio_adc_rx #(.WL(WL), .CNT_W(CNT_W)) dut (
      .aud_bclk (aud_bclk),
      .rst_n    (rst_n),
      .en       (en),
      .aud_lrc  (aud_lrc),
      .mic_l    (mic_l),
      .mic_r    (mic_r),
      .rx       (rx_if.master)
   );

   always #5 aud_bclk = ~aud_bclk;

   typedef struct {
      logic [WL-1:0]    l;
      logic [WL-1:0]    r;
      logic             ovf;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   exp_t             sb[$];
   int               checks   = 0;
   int               failures = 0;
   logic             model_valid = 1'b0;
   logic [CNT_W-1:0] model_cnt   = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_cycle();
      @(negedge aud_bclk);
      if (rx_if.rx_ready) model_valid = 1'b0;
   endtask

   // Called just after a falling edge; returns on the falling edge after the last driven bit's sample.
   task automatic send_frame(input logic [WL-1:0] l, input logic [WL-1:0] r,
                             input int unsigned nbits, input logic rdy_body,
                             input logic rdy_last, input logic full, input logic exp_err);
      exp_t e;
      if (full) begin
         e.l   = l;
         e.r   = r;
         e.ovf = (rdy_body ? 1'b0 : model_valid) & ~rdy_last;
         e.cnt = model_cnt + 1'b1;
         sb.push_back(e);
         model_valid = 1'b1;
         model_cnt   = e.cnt;
      end else if (rdy_body || (nbits == WL && rdy_last)) begin
         model_valid = 1'b0;
      end
      aud_lrc         = 1'b1;
      rx_if.rx_ready  = rdy_body;
      @(negedge aud_bclk);
      aud_lrc = 1'b0;
      @(negedge aud_bclk);
      check("frame_err", 32'(rx_if.frame_err), 32'(exp_err));
      for (int unsigned i = 0; i < nbits; i++) begin
         if (i != 0) @(negedge aud_bclk);
         if (i == WL - 1) rx_if.rx_ready = rdy_last;
         mic_l = l[WL-1-i];
         mic_r = r[WL-1-i];
      end
      @(negedge aud_bclk);
      if (full) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL sb_underflow observed=0 expected=1");
         end else begin
            e = sb.pop_front();
            check("data_l",   32'(rx_if.rx_data_l),   32'(e.l));
            check("data_r",   32'(rx_if.rx_data_r),   32'(e.r));
            check("valid",    32'(rx_if.rx_valid),    32'(1'b1));
            check("overflow", 32'(rx_if.rx_overflow), 32'(e.ovf));
            check("frame_cnt",32'(rx_if.frame_cnt),   32'(e.cnt));
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rx_if.rx_ready = 1'b0;
      repeat (3) @(negedge aud_bclk);
      check("rst_data_l", 32'(rx_if.rx_data_l),   32'(0));
      check("rst_data_r", 32'(rx_if.rx_data_r),   32'(0));
      check("rst_valid",  32'(rx_if.rx_valid),    32'(0));
      check("rst_ovf",    32'(rx_if.rx_overflow), 32'(0));
      check("rst_err",    32'(rx_if.frame_err),   32'(0));
      check("rst_cnt",    32'(rx_if.frame_cnt),   32'(0));
      rst_n = 1'b1;
      en    = 1'b1;
      @(negedge aud_bclk);

      // basic frame
      send_frame(24'h123456, 24'hFEDCBA, WL, 1'b0, 1'b0, 1'b1, 1'b0);

      // backpressure across two frames
      rx_if.rx_ready = 1'b1;
      idle_cycle();
      check("drain_valid", 32'(rx_if.rx_valid), 32'(0));
      rx_if.rx_ready = 1'b0;
      send_frame(24'h000001, 24'h0A0B0C, WL, 1'b0, 1'b0, 1'b1, 1'b0);
      send_frame(24'h7FFFFF, 24'h123123, WL, 1'b0, 1'b0, 1'b1, 1'b0);
      idle_cycle();
      check("ovf_one_cycle", 32'(rx_if.rx_overflow), 32'(0));
      check("bp_valid",      32'(rx_if.rx_valid),    32'(1));
      check("bp_data_l",     32'(rx_if.rx_data_l),   32'(24'h7FFFFF));

      // completion coincides with a transfer
      send_frame(24'hABCDEF, 24'h654321, WL, 1'b0, 1'b1, 1'b1, 1'b0);
      rx_if.rx_ready = 1'b0;

      // truncated frame, then a full one
      send_frame(24'h555555, 24'hAAAAAA, 10, 1'b0, 1'b0, 1'b0, 1'b0);
      check("trunc_hold_l",   32'(rx_if.rx_data_l), 32'(24'hABCDEF));
      check("trunc_hold_r",   32'(rx_if.rx_data_r), 32'(24'h654321));
      check("trunc_hold_cnt", 32'(rx_if.frame_cnt), 32'(model_cnt));
      send_frame(24'h800000, 24'h00FF00, WL, 1'b0, 1'b0, 1'b1, 1'b1);

      // reset at bit 12
      send_frame(24'h13579B, 24'h2468AC, 12, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_data_l", 32'(rx_if.rx_data_l),   32'(0));
      check("mid_rst_data_r", 32'(rx_if.rx_data_r),   32'(0));
      check("mid_rst_valid",  32'(rx_if.rx_valid),    32'(0));
      check("mid_rst_ovf",    32'(rx_if.rx_overflow), 32'(0));
      check("mid_rst_err",    32'(rx_if.frame_err),   32'(0));
      check("mid_rst_cnt",    32'(rx_if.frame_cnt),   32'(0));
      model_valid = 1'b0;
      model_cnt   = '0;
      sb.delete();
      @(negedge aud_bclk);
      rst_n = 1'b1;

      // en dropped mid-frame, then held low for two frames
      send_frame(24'h0000FF, 24'hFF0000, 8, 1'b0, 1'b0, 1'b0, 1'b0);
      en = 1'b0;
      send_frame(24'h111111, 24'h222222, WL, 1'b0, 1'b0, 1'b0, 1'b0);
      send_frame(24'h333333, 24'h444444, WL, 1'b0, 1'b0, 1'b0, 1'b0);
      check("en_low_cnt",   32'(rx_if.frame_cnt), 32'(0));
      check("en_low_valid", 32'(rx_if.rx_valid),  32'(0));
      check("en_low_err",   32'(rx_if.frame_err), 32'(0));
      en = 1'b1;
      send_frame(24'h0F0F0F, 24'hF0F0F0, WL, 1'b0, 1'b0, 1'b1, 1'b0);

      // randomized loopback
      for (int n = 0; n < 1000; n++) begin
         send_frame(WL'($urandom()), WL'($urandom()), WL,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      end
      check("cnt_wrap", 32'(rx_if.frame_cnt), 32'(4'd9));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
